// File: rtl/audio_dac_serializer.sv
// I2S transmitter for the mono filter output: a one-entry holding register feeds
// a frame register that is sent in both the left and right slots of each frame.
module audio_dac_serializer #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic                underrun,
  output logic                frame_start,
  output logic                dac_bclk,
  output logic                dac_lrck,
  output logic                dac_data
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int POS_W = $clog2(SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);

  logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
  logic                bclk_reg, bclk_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic                lrck_reg, lrck_next;
  logic                data_reg, data_next;
  logic [SAMPLE_W-1:0] hold_reg, hold_next;
  logic                hold_full_reg, hold_full_next;
  logic [SAMPLE_W-1:0] frame_sample_reg, frame_sample_next;
  logic                underrun_reg, underrun_next;
  logic                frame_start_reg, frame_start_next;

  logic                toggle;
  logic                fall;
  logic                boundary;
  logic                accept;
  logic [BIT_W-1:0]    bit_inc;
  logic                in_right;
  logic [BIT_W-1:0]    pos_full;
  logic [POS_W-1:0]    slot_pos;
  logic [SLOT_W-1:0]   slot_vec;

  // slot_vec[b] is the serial bit for slot position b: one leading zero for the
  // I2S delay, the sample MSB first, then zero padding to the end of the slot.
  for (genvar gi = 0; gi < SLOT_W; gi++) begin : g_slot
    if (gi >= 1 && gi <= SAMPLE_W) begin : g_bit
      assign slot_vec[gi] = frame_sample_reg[SAMPLE_W-gi];
    end else begin : g_pad
      assign slot_vec[gi] = 1'b0;
    end
  end

  assign toggle   = (div_cnt_reg == DIV_LAST);
  assign fall     = toggle && bclk_reg;
  assign bit_inc  = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
  assign in_right = (bit_inc >= SLOT_LEN);
  assign pos_full = in_right ? (bit_inc - SLOT_LEN) : bit_inc;
  assign slot_pos = pos_full[POS_W-1:0];
  assign boundary = fall && (bit_inc == '0);
  assign accept   = sample_valid && !hold_full_reg;

  always_comb begin
    div_cnt_next      = toggle ? '0 : div_cnt_reg + 1'b1;
    bclk_next         = bclk_reg ^ toggle;
    bit_cnt_next      = bit_cnt_reg;
    lrck_next         = lrck_reg;
    data_next         = data_reg;
    hold_next         = hold_reg;
    hold_full_next    = hold_full_reg;
    frame_sample_next = frame_sample_reg;
    underrun_next     = underrun_reg;
    frame_start_next  = boundary;

    if (fall) begin
      bit_cnt_next = bit_inc;
      lrck_next    = in_right;
      data_next    = slot_vec[slot_pos];
    end

    // Accept needs an empty register and a load needs a full one, so they never collide.
    if (accept) begin
      hold_next      = sample_in;
      hold_full_next = 1'b1;
    end else if (boundary && hold_full_reg) begin
      hold_full_next = 1'b0;
    end

    if (boundary && hold_full_reg) begin
      frame_sample_next = hold_reg;
    end

    // An empty frame start outranks a same-cycle clear.
    if (boundary && !hold_full_reg) begin
      underrun_next = 1'b1;
    end else if (underrun_clr) begin
      underrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg      <= '0;
      bclk_reg         <= 1'b0;
      bit_cnt_reg      <= BIT_LAST;
      lrck_reg         <= 1'b0;
      data_reg         <= 1'b0;
      hold_reg         <= '0;
      hold_full_reg    <= 1'b0;
      frame_sample_reg <= '0;
      underrun_reg     <= 1'b0;
      frame_start_reg  <= 1'b0;
    end else begin
      div_cnt_reg      <= div_cnt_next;
      bclk_reg         <= bclk_next;
      bit_cnt_reg      <= bit_cnt_next;
      lrck_reg         <= lrck_next;
      data_reg         <= data_next;
      hold_reg         <= hold_next;
      hold_full_reg    <= hold_full_next;
      frame_sample_reg <= frame_sample_next;
      underrun_reg     <= underrun_next;
      frame_start_reg  <= frame_start_next;
    end
  end

  assign sample_ready = !hold_full_reg;
  assign underrun     = underrun_reg;
  assign frame_start  = frame_start_reg;
  assign dac_bclk     = bclk_reg;
  assign dac_lrck     = lrck_reg;
  assign dac_data     = data_reg;

endmodule
